noc_inject_arbiter: RTL and testbench
=====================================

Name: noc_inject_arbiter

Overview:
Shares one net_router injection port (the 17-bit in_free flit input) among N_REQ local requesters, e.g. sm_cpu inject, a link test generator and a debug/config source.
Arbitration is round-robin and packet-atomic: a granted requester keeps the port until it delivers its last flit.
The output is a registered single-flit holding stage with a router-side accept handshake and a stall watchdog.
One instance sits between each router and its local sources inside MAIN_fpga*.

Parameters:
N_REQ, 4, number of requesters (2..8)
FLIT_W, 17, flit width; bit FLIT_W-1 is the valid flag, bits [FLIT_W-2:0] are the payload
GID_W, 2, grant-id width, >= clog2(N_REQ)
TIMEOUT, 255, cycles a held flit may wait for an ack before stall is raised (1..255)

Ports:
clk  input  1  system clock (divided clock in MAIN_fpga*)
rst_n  input  1  asynchronous active-low reset
req_valid  input  N_REQ  requester i has a flit presented
req_flit  input  N_REQ*FLIT_W  flit of requester i at [i*FLIT_W +: FLIT_W]; its valid bit is ignored
req_last  input  N_REQ  the presented flit is the last flit of its packet
req_ready  output  N_REQ  combinational one-hot; the flit of requester i is captured at this clock edge
inj_flit  output  FLIT_W  registered flit driven to the router in_free input
inj_ack  input  1  router consumes inj_flit at this edge
grant_id  output  GID_W  requester that owns the held flit or locked packet
busy  output  1  a flit is held (state HOLD)
stall  output  1  sticky watchdog flag

Behaviour:
- Reset is asynchronous on rst_n=0 and forces:
  - inj_flit=0, busy=0, stall=0, grant_id=0
  - state IDLE, lock=0, rr_ptr=N_REQ-1 (requester 0 is served first), wait counter=0
- States:
  - IDLE: inj_flit=0, busy=0.
  - HOLD: inj_flit[FLIT_W-1]=1, payload held stable, busy=1.
- Capture opportunity: the cycle is in IDLE, or in HOLD with inj_ack=1.
  - inj_ack in IDLE is ignored.
- Selection on a capture opportunity:
  - If lock=1, only requester grant_id is eligible.
  - If lock=0, pick the first requester with req_valid=1 in the order rr_ptr+1, rr_ptr+2, ... wrapping modulo N_REQ.
- Capture of requester s at the edge:
  - req_ready[s]=1 combinationally in that cycle; all other req_ready bits are 0.
  - inj_flit <= {1'b1, req_flit_s[FLIT_W-2:0]}; grant_id <= s; state HOLD.
  - lock <= ~req_last[s]. If req_last[s]=1, rr_ptr <= s.
- Ack with no eligible flit: HOLD with inj_ack=1 and no capture gives state IDLE and inj_flit <= 0.
  - If lock=1, grant_id is retained and other requesters stay blocked until the owner presents its next flit.
- Throughput:
  - Back-to-back flits at 1 per cycle when inj_ack is held high.
  - Latency from req_valid to inj_flit valid is 1 cycle.
- Watchdog:
  - The counter increments each HOLD cycle without inj_ack, saturating at TIMEOUT.
  - stall <= 1 when the count reaches TIMEOUT.
  - inj_ack clears both the counter and stall.
- req_ready never asserts without a capture. A requester must hold req_valid, req_flit and req_last stable until it sees req_ready.
- A reset asserted mid-packet drops the held flit and the lock; no partial-packet recovery is provided.
- When a single requester is valid, it wins regardless of rr_ptr.

Test Plan:
- Reset, all req_valid=0, 10 cycles -> inj_flit=0x00000, busy=0, req_ready=0, stall=0; inj_ack pulses have no effect.
- req_valid=4'b1111 (each last=1, payloads 0xA0..0xA3), inj_ack=1 continuously:
  - required grant order 0,1,2,3,0.
  - inj_flit = 0x100A0, 0x100A1, 0x100A2, 0x100A3 on consecutive cycles, one req_ready per cycle.
- Requester 2 sends a 3-flit packet (last on flit 3) while requester 0 is continuously valid:
  - the 3 flits of requester 2 appear contiguously, then requester 0 follows.
  - grant_id=2 throughout the packet, including a 4-cycle gap in req_valid[2] mid-packet during which the output goes IDLE and requester 0 is not served.
- Hold inj_ack=0 with a flit held, TIMEOUT=255:
  - stall rises exactly at the 255th HOLD cycle and inj_flit stays unchanged.
  - a single inj_ack clears stall and captures the next flit at the same edge.
- rst_n=0 asynchronously mid-packet (between clock edges) -> inj_flit=0 and lock=0 immediately.
  - After release, requester 0 is served first.

Source files
------------

// File: rtl/noc_inject_arbiter.sv
// noc_inject_arbiter
//   Shares one router injection port among N_REQ local requesters.
//   Arbitration is round-robin and packet-atomic: once a requester's first
//   flit is taken, only that requester may inject until it delivers the flit
//   marked last. The chosen flit is held in a single output register until
//   the router acknowledges it. A watchdog flags a flit that waits too long.
//
// Handshakes:
//   Requester side: requester i presents req_valid[i]/req_flit/req_last and
//   holds them stable. The flit is taken at the clock edge in a cycle where
//   req_ready[i]=1. req_ready is combinational and one-hot, and it never
//   asserts without a capture.
//   Router side: inj_flit[FLIT_W-1] is the valid flag. The router consumes the
//   held flit at an edge where inj_ack=1. A new flit may be captured at that
//   same edge. inj_ack is ignored while nothing is held.
//
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   req_valid   [N_REQ]          requester i presents a flit
//   req_flit    [N_REQ*FLIT_W]   flit i at [i*FLIT_W +: FLIT_W] (valid bit ignored)
//   req_last    [N_REQ]          presented flit closes its packet
//   req_ready   [N_REQ]          one-hot capture strobe (combinational)
//   inj_flit    [FLIT_W]         registered flit to the router
//   inj_ack                      router consumes inj_flit this edge
//   grant_id    [GID_W]          owner of the held flit / locked packet
//   busy                         a flit is held (FSM state HOLD)
//   stall                        sticky watchdog flag, cleared by inj_ack
module noc_inject_arbiter #(
  parameter int N_REQ   = 4,
  parameter int FLIT_W  = 17,
  parameter int GID_W   = 2,
  parameter int TIMEOUT = 255
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ*FLIT_W-1:0]   req_flit,
  input  logic [N_REQ-1:0]          req_last,
  output logic [N_REQ-1:0]          req_ready,
  output logic [FLIT_W-1:0]         inj_flit,
  input  logic                      inj_ack,
  output logic [GID_W-1:0]          grant_id,
  output logic                      busy,
  output logic                      stall
);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic                lock;
  logic [GID_W-1:0]    rr_ptr;
  logic [7:0]          wait_cnt;

  logic                cap_opp;
  logic                found;
  logic                capture;
  logic [GID_W-1:0]    sel;
  logic [FLIT_W-2:0]   sel_payload;
  logic                sel_last;

  // The per-requester valid bits of req_flit carry no meaning here.
  logic [N_REQ-1:0]    unused_flit_valid;

  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      unused_flit_valid[i] = req_flit[i*FLIT_W + FLIT_W - 1];
    end
  end

  // A capture can happen when the output register is empty or being emptied.
  assign cap_opp = (state == IDLE) || inj_ack;

  // Selection. While a packet is locked only its owner is eligible.
  // Otherwise scan rr_ptr+N_REQ down to rr_ptr+1 so the last hit written is
  // the first requester in round-robin order after rr_ptr.
  always_comb begin
    int idx;
    idx   = 0;
    found = 1'b0;
    sel   = '0;
    if (lock) begin
      if (req_valid[grant_id]) begin
        found = 1'b1;
        sel   = grant_id;
      end
    end else begin
      for (int k = N_REQ; k >= 1; k--) begin
        idx = (int'(rr_ptr) + k) % N_REQ;
        if (req_valid[idx]) begin
          found = 1'b1;
          sel   = GID_W'(idx);
        end
      end
    end
  end

  assign capture = cap_opp && found;

  always_comb begin
    sel_payload = '0;
    sel_last    = 1'b0;
    req_ready   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (int'(sel) == i) begin
        sel_payload  = req_flit[i*FLIT_W +: FLIT_W-1];
        sel_last     = req_last[i];
        req_ready[i] = capture;
      end
    end
  end

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM: next state
  always_comb begin
    state_nxt = state;
    if (capture) begin
      state_nxt = HOLD;
    end else if ((state == HOLD) && inj_ack) begin
      state_nxt = IDLE;
    end
  end

  assign busy = (state == HOLD);

  // Output register, packet lock and round-robin pointer.
  // rr_ptr only advances at packet end, so a locked packet never disturbs
  // the fairness order. grant_id is kept while IDLE so a locked owner
  // stays identified across gaps in its packet.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inj_flit <= '0;
      grant_id <= '0;
      lock     <= 1'b0;
      rr_ptr   <= GID_W'(N_REQ-1);
    end else if (capture) begin
      inj_flit <= {1'b1, sel_payload};
      grant_id <= sel;
      lock     <= ~sel_last;
      if (sel_last) begin
        rr_ptr <= sel;
      end
    end else if ((state == HOLD) && inj_ack) begin
      inj_flit <= '0;
    end
  end

  // Watchdog. wait_cnt counts HOLD cycles without ack and saturates.
  // stall is set at the edge that closes the TIMEOUT-th waiting cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
      stall    <= 1'b0;
    end else if (state == HOLD) begin
      if (inj_ack) begin
        wait_cnt <= '0;
        stall    <= 1'b0;
      end else begin
        if (wait_cnt != 8'(TIMEOUT)) begin
          wait_cnt <= wait_cnt + 8'd1;
        end
        if (wait_cnt >= 8'(TIMEOUT-1)) begin
          stall <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_noc_inject_arbiter.sv
// Directed bench for noc_inject_arbiter (N_REQ=4, FLIT_W=17, TIMEOUT=255).
// Captures are predicted into a scoreboard queue when the stimulus is driven
// and checked when the flit appears on inj_flit one edge later.
module tb_noc_inject_arbiter;

  localparam int N_REQ   = 4;
  localparam int FLIT_W  = 17;
  localparam int GID_W   = 2;
  localparam int TIMEOUT = 255;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [N_REQ-1:0]        req_valid = '0;
  logic [N_REQ*FLIT_W-1:0] req_flit  = '0;
  logic [N_REQ-1:0]        req_last  = '0;
  logic [N_REQ-1:0]        req_ready;
  logic [FLIT_W-1:0]       inj_flit;
  logic                    inj_ack = 1'b0;
  logic [GID_W-1:0]        grant_id;
  logic                    busy;
  logic                    stall;

  noc_inject_arbiter #(
    .N_REQ(N_REQ), .FLIT_W(FLIT_W), .GID_W(GID_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_flit(req_flit), .req_last(req_last),
    .req_ready(req_ready), .inj_flit(inj_flit), .inj_ack(inj_ack),
    .grant_id(grant_id), .busy(busy), .stall(stall)
  );

  // ---------------- scoreboard ----------------
  logic [FLIT_W-1:0] exp_q[$];
  logic [GID_W-1:0]  exp_gid_q[$];
  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got 0x%0h required 0x%0h", tag, obs, exp);
    end
  endtask

  // Predict a capture of requester i with the given payload.
  task automatic push_exp(input int i, input logic [FLIT_W-2:0] payload);
    exp_q.push_back({1'b1, payload});
    exp_gid_q.push_back(GID_W'(i));
  endtask

  // Compare the registered output against the oldest prediction.
  task automatic pop_chk(input string tag);
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $error("FAIL %s: got 0x%0h required <no prediction>", tag, inj_flit);
    end else begin
      chk({tag, "_flit"}, 32'(inj_flit), 32'(exp_q.pop_front()));
      chk({tag, "_gid"},  32'(grant_id), 32'(exp_gid_q.pop_front()));
      chk({tag, "_busy"}, 32'(busy), 32'd1);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_req(input int i, input logic v, input logic [FLIT_W-2:0] payload,
                         input logic last);
    req_valid[i] = v;
    req_flit[i*FLIT_W +: FLIT_W] = {1'b0, payload};
    req_last[i] = last;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    // Reset with nothing requested.
    #1;
    chk("rst_flit", 32'(inj_flit), 32'h0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_gid", 32'(grant_id), 32'd0);
    #22 rst_n = 1'b1;
    tick();
    for (int c = 0; c < 10; c++) begin
      inj_ack = 1'($urandom_range(0, 1));
      #1;
      chk("idle_ready", 32'(req_ready), 32'h0);
      tick();
      chk("idle_flit", 32'(inj_flit), 32'h0);
      chk("idle_busy", 32'(busy), 32'd0);
      chk("idle_stall", 32'(stall), 32'd0);
    end

    // All four requesters, single-flit packets, ack held high.
    inj_ack = 1'b1;
    for (int i = 0; i < N_REQ; i++) set_req(i, 1'b1, 16'h00A0 + 16'(i), 1'b1);
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("rr_ready", 32'(req_ready), 32'(1 << (k % N_REQ)));
      push_exp(k % N_REQ, 16'h00A0 + 16'(k % N_REQ));
      tick();
      pop_chk("rr");
    end
    req_valid = '0;
    #1;
    chk("drain_ready", 32'(req_ready), 32'h0);
    tick();
    chk("drain_flit", 32'(inj_flit), 32'h0);
    chk("drain_busy", 32'(busy), 32'd0);

    // Requester 2 sends a 3-flit packet while requester 0 stays valid.
    set_req(0, 1'b1, 16'h00F0, 1'b1);
    set_req(2, 1'b1, 16'h00B1, 1'b0);
    #1;
    chk("pkt1_ready", 32'(req_ready), 32'h4);
    push_exp(2, 16'h00B1);
    tick();
    pop_chk("pkt1");
    set_req(2, 1'b1, 16'h00B2, 1'b0);
    #1;
    chk("pkt2_ready", 32'(req_ready), 32'h4);
    push_exp(2, 16'h00B2);
    tick();
    pop_chk("pkt2");
    req_valid[2] = 1'b0;
    for (int g = 0; g < 4; g++) begin
      #1;
      chk("gap_ready", 32'(req_ready), 32'h0);
      tick();
      chk("gap_flit", 32'(inj_flit), 32'h0);
      chk("gap_busy", 32'(busy), 32'd0);
      chk("gap_gid", 32'(grant_id), 32'd2);
    end
    set_req(2, 1'b1, 16'h00B3, 1'b1);
    #1;
    chk("pkt3_ready", 32'(req_ready), 32'h4);
    push_exp(2, 16'h00B3);
    tick();
    pop_chk("pkt3");
    req_valid[2] = 1'b0;
    #1;
    chk("after_pkt_ready", 32'(req_ready), 32'h1);
    push_exp(0, 16'h00F0);
    tick();
    pop_chk("after_pkt");

    // Watchdog: requester 0's flit held with no ack, requester 1 waiting.
    inj_ack = 1'b0;
    req_valid[0] = 1'b0;
    set_req(1, 1'b1, 16'h00C1, 1'b1);
    #1;
    chk("wd_ready", 32'(req_ready), 32'h0);
    for (int c = 1; c <= TIMEOUT; c++) begin
      tick();
      if (c == TIMEOUT - 1) chk("wd_stall_early", 32'(stall), 32'd0);
    end
    chk("wd_stall", 32'(stall), 32'd1);
    chk("wd_flit", 32'(inj_flit), 32'h100F0);
    chk("wd_busy", 32'(busy), 32'd1);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("wd_sticky", 32'(stall), 32'd1);
    end
    inj_ack = 1'b1;
    #1;
    chk("wd_ack_ready", 32'(req_ready), 32'h2);
    push_exp(1, 16'h00C1);
    tick();
    pop_chk("wd_ack");
    chk("wd_clear", 32'(stall), 32'd0);

    // Reset asserted mid-packet between edges.
    req_valid = '0;
    set_req(3, 1'b1, 16'h00D3, 1'b0);
    #1;
    chk("mid_ready", 32'(req_ready), 32'h8);
    push_exp(3, 16'h00D3);
    tick();
    pop_chk("mid");
    #3 rst_n = 1'b0;
    #1;
    chk("arst_flit", 32'(inj_flit), 32'h0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_gid", 32'(grant_id), 32'd0);
    exp_q.delete();
    exp_gid_q.delete();
    for (int i = 0; i < N_REQ; i++) set_req(i, 1'b1, 16'h00E0 + 16'(i), 1'b1);
    #2 rst_n = 1'b1;
    #1;
    chk("post_rst_ready", 32'(req_ready), 32'h1);
    push_exp(0, 16'h00E0);
    tick();
    pop_chk("post_rst0");
    #1;
    chk("post_rst_ready1", 32'(req_ready), 32'h2);
    push_exp(1, 16'h00E1);
    tick();
    pop_chk("post_rst1");

    chk("queue_empty", 32'(exp_q.size()), 32'd0);

    // ---------------- report ----------------
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global guard so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
